sprite_scan_ctrl: RTL

OAM scan sequencer that fills the ten-slot sprite store once per scanline. During the mode-2 window it walks all 40 OAM entries, reads each Y coordinate and tests it against the current line. For each hit it issues a one-hot store strobe carrying the 6-bit sprite index and 4-bit row-in-sprite, so the sprite store's index and line latches load in hit order. It sits between the PPU timing logic (line start, LY, LCDC) and the sprite store's per-slot latch enables.

---
 rtl/sprite_scan_ctrl.sv | 116 +++++++++++
 1 files changed

// File: rtl/sprite_scan_ctrl.sv
// OAM scan sequencer: walks every OAM entry once per line, compares Y against the
// current line, and strobes one sprite-store slot per hit in hit order.
module sprite_scan_ctrl #(
  parameter int unsigned NUM_SLOTS = 10,
  parameter int unsigned NUM_OAM   = 40
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 scan_start,
  input  logic [7:0]           ly,
  input  logic                 obj_size,
  output logic [5:0]           oam_addr,
  input  logic [7:0]           oam_y,
  output logic [NUM_SLOTS-1:0] store_en,
  output logic [5:0]           store_index,
  output logic [3:0]           store_line,
  output logic [3:0]           sprite_count,
  output logic                 scan_busy,
  output logic                 scan_done
);

  localparam logic [5:0] LastIdx = 6'(NUM_OAM - 1);
  localparam logic [3:0] MaxHits = 4'(NUM_SLOTS);

  typedef enum logic [0:0] {StIdle, StScan} state_e;

  state_e                 state_q;
  logic [7:0]             ly_q;
  logic                   size_q;
  logic [5:0]             idx_q;
  logic                   ph_q;
  logic [5:0]             addr_q;
  logic [NUM_SLOTS-1:0]   store_en_q;
  logic [5:0]             store_index_q;
  logic [3:0]             store_line_q;
  logic [3:0]             cnt_q;
  logic                   busy_q;
  logic                   done_q;

  logic [8:0] diff;
  logic [8:0] height;
  logic       hit;

  // Bit 8 set means the sprite starts below the current line (or wrapped): never a hit.
  always_comb begin
    diff   = {1'b0, ly_q} + 9'd16 - {1'b0, oam_y};
    height = size_q ? 9'd16 : 9'd8;
    hit    = !diff[8] && (diff < height);
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q       <= StIdle;
      ly_q          <= '0;
      size_q        <= 1'b0;
      idx_q         <= '0;
      ph_q          <= 1'b0;
      addr_q        <= '0;
      store_en_q    <= '0;
      store_index_q <= '0;
      store_line_q  <= '0;
      cnt_q         <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      store_en_q <= '0;
      done_q     <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (scan_start) begin
            ly_q    <= ly;
            size_q  <= obj_size;
            idx_q   <= '0;
            ph_q    <= 1'b0;
            addr_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StScan;
          end
        end
        StScan: begin
          if (!ph_q) begin
            ph_q <= 1'b1;
          end else begin
            if (hit && (cnt_q < MaxHits)) begin
              store_en_q    <= NUM_SLOTS'(1) << cnt_q;
              store_index_q <= idx_q;
              store_line_q  <= diff[3:0];
              cnt_q         <= cnt_q + 4'd1;
            end
            if (idx_q == LastIdx) begin
              // Address stays on the last entry while idle.
              state_q <= StIdle;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              idx_q  <= idx_q + 6'd1;
              addr_q <= idx_q + 6'd1;
              ph_q   <= 1'b0;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign oam_addr     = addr_q;
  assign store_en     = store_en_q;
  assign store_index  = store_index_q;
  assign store_line   = store_line_q;
  assign sprite_count = cnt_q;
  assign scan_busy    = busy_q;
  assign scan_done    = done_q;

endmodule
